// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int RD_W_DEF = 6;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_ALU = 2'd1;
  localparam logic [1:0] PC_SRC_MEM = 2'd2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution from EX/WB flags; also reused by verification models.
module branch_resolve
  import pipe_ctrl_pkg::*;
(
  input  logic       wb_n_i,
  input  logic       wb_z_i,
  input  logic       wb_branch_z_i,
  input  logic       wb_branch_n_i,
  input  logic       wb_jump_i,
  input  logic       wb_jump_mem_i,
  output logic       taken_o,
  output logic [1:0] pc_src_sel_o
);

  assign taken_o = (wb_branch_z_i & wb_z_i) | (wb_branch_n_i & wb_n_i) | wb_jump_i | wb_jump_mem_i;

  always_comb begin
    pc_src_sel_o = PC_SRC_SEQ;
    if (wb_jump_mem_i)  pc_src_sel_o = PC_SRC_MEM;
    else if (taken_o)   pc_src_sel_o = PC_SRC_ALU;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: redirect on WB branch/jump, load-use bubbles, PC/pipe-reg enables and flushes.
// Define HAZARD_PERF_EN to build the stall/redirect performance counters.
//   state | meaning
//   RUN   | normal flow; branches evaluated, load-use hazards detected
//   STALL | extra load-use bubbles beyond the first
//   DRAIN | post-redirect window, WB branch/jump inputs ignored
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RD_W               = RD_W_DEF,
  parameter int LOAD_STALL_CYC     = 1,
  parameter int DRAIN_CYC          = 2,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RD_W-1:0] id_rs,
  input  logic [RD_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_wrt,
  input  logic            ex_mem_to_reg,
  input  logic            wb_n,
  input  logic            wb_z,
  input  logic            wb_branch_z,
  input  logic            wb_branch_n,
  input  logic            wb_jump,
  input  logic            wb_jump_mem,
  output logic [1:0]      pc_src_sel,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exwb_flush,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     redirect_count
);

  // The hazard cycle in RUN is the first bubble, so STALL covers the remaining LOAD_STALL_CYC-1.
  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYC - 2);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wb_taken, taken, hazard, rd_zero;
  logic [1:0] wb_sel;

  branch_resolve u_branch_resolve (
    .wb_n_i        (wb_n),
    .wb_z_i        (wb_z),
    .wb_branch_z_i (wb_branch_z),
    .wb_branch_n_i (wb_branch_n),
    .wb_jump_i     (wb_jump),
    .wb_jump_mem_i (wb_jump_mem),
    .taken_o       (wb_taken),
    .pc_src_sel_o  (wb_sel)
  );

  assign rd_zero = (ZERO_REG_HARDWIRED != 0) && (ex_rd == '0);
  assign hazard  = ex_mem_to_reg & ex_reg_wrt & ~rd_zero &
                   ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  assign taken   = wb_taken & (state_q != DRAIN);

  always_comb begin
    pc_src_sel = PC_SRC_SEQ;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exwb_flush = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exwb_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (taken) begin
      // The hazard's ID instruction is flushed here, so any stall is dropped.
      pc_src_sel = wb_sel;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exwb_flush = 1'b1;
      state_d    = DRAIN;
      cnt_d      = DRAIN_LOAD;
    end else begin
      if (hazard || state_q == STALL) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      case (state_q)
        RUN: begin
          if (hazard && LOAD_STALL_CYC > 1) begin
            state_d = STALL;
            cnt_d   = STALL_LOAD;
          end
        end
        STALL: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 3'd1;
        end
        DRAIN: begin
          if (hazard && LOAD_STALL_CYC > 1) begin
            state_d = STALL;
            cnt_d   = STALL_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!pc_write && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (taken && redir_q != 32'hFFFF_FFFF)     redir_q <= redir_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three parameterisations share one stimulus stream.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] O_RST  = 7'b00_00111;
  localparam logic [6:0] O_NORM = 7'b00_11000;
  localparam logic [6:0] O_STL  = 7'b00_00010;
  localparam logic [6:0] O_RD1  = 7'b01_11111;
  localparam logic [6:0] O_RD2  = 7'b10_11111;

  // wb vector bits: {jump_mem, jump, branch_n, branch_z, n, z}
  localparam logic [5:0] WB_NONE     = 6'b000000;
  localparam logic [5:0] WB_BZ_TAKEN = 6'b000101;
  localparam logic [5:0] WB_J        = 6'b010000;
  localparam logic [5:0] WB_BN_NOT   = 6'b001000;
  localparam logic [5:0] WB_BN_TAKEN = 6'b001010;
  localparam logic [5:0] WB_JMJ      = 6'b110000;

`ifdef HAZARD_PERF_EN
  localparam int EXP_STALLS = 3;
  localparam int EXP_REDIRS = 2;
`else
  localparam int EXP_STALLS = 0;
  localparam int EXP_REDIRS = 0;
`endif

  typedef struct {
    int         dut;
    bit         perf;
    logic [6:0] exp;
    int         es;
    int         er;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_reg_wrt = 1'b0, ex_mem_to_reg = 1'b0;
  logic       wb_n = 1'b0, wb_z = 1'b0, wb_branch_z = 1'b0, wb_branch_n = 1'b0;
  logic       wb_jump = 1'b0, wb_jump_mem = 1'b0;

  logic [1:0]  sel_w   [3];
  logic        pcw_w   [3];
  logic        ifw_w   [3];
  logic        iff_w   [3];
  logic        idf_w   [3];
  logic        exf_w   [3];
  logic [31:0] stall_w [3];
  logic [31:0] redir_w [3];

  always #5 clk = ~clk;

  // dut 0: LOAD_STALL_CYC=1, ZERO_REG_HARDWIRED=1
  pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .DRAIN_CYC(2), .ZERO_REG_HARDWIRED(1)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_reg_wrt(ex_reg_wrt), .ex_mem_to_reg(ex_mem_to_reg),
    .wb_n(wb_n), .wb_z(wb_z), .wb_branch_z(wb_branch_z), .wb_branch_n(wb_branch_n),
    .wb_jump(wb_jump), .wb_jump_mem(wb_jump_mem),
    .pc_src_sel(sel_w[0]), .pc_write(pcw_w[0]), .ifid_write(ifw_w[0]),
    .ifid_flush(iff_w[0]), .idex_flush(idf_w[0]), .exwb_flush(exf_w[0]),
    .stall_cycles(stall_w[0]), .redirect_count(redir_w[0])
  );

  // dut 1: LOAD_STALL_CYC=3
  pipe_hazard_ctrl #(.LOAD_STALL_CYC(3), .DRAIN_CYC(2), .ZERO_REG_HARDWIRED(1)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_reg_wrt(ex_reg_wrt), .ex_mem_to_reg(ex_mem_to_reg),
    .wb_n(wb_n), .wb_z(wb_z), .wb_branch_z(wb_branch_z), .wb_branch_n(wb_branch_n),
    .wb_jump(wb_jump), .wb_jump_mem(wb_jump_mem),
    .pc_src_sel(sel_w[1]), .pc_write(pcw_w[1]), .ifid_write(ifw_w[1]),
    .ifid_flush(iff_w[1]), .idex_flush(idf_w[1]), .exwb_flush(exf_w[1]),
    .stall_cycles(stall_w[1]), .redirect_count(redir_w[1])
  );

  // dut 2: ZERO_REG_HARDWIRED=0
  pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .DRAIN_CYC(2), .ZERO_REG_HARDWIRED(0)) dut_c (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_reg_wrt(ex_reg_wrt), .ex_mem_to_reg(ex_mem_to_reg),
    .wb_n(wb_n), .wb_z(wb_z), .wb_branch_z(wb_branch_z), .wb_branch_n(wb_branch_n),
    .wb_jump(wb_jump), .wb_jump_mem(wb_jump_mem),
    .pc_src_sel(sel_w[2]), .pc_write(pcw_w[2]), .ifid_write(ifw_w[2]),
    .ifid_flush(iff_w[2]), .idex_flush(idf_w[2]), .exwb_flush(exf_w[2]),
    .stall_cycles(stall_w[2]), .redirect_count(redir_w[2])
  );

  // hz: 0 none, 1 rs load-use on r5, 2 load-use on r0, 3 rt load-use on r5
  task automatic step(input bit rst, input int hz, input logic [5:0] wb);
    @(posedge clk);
    #1;
    reset         = rst;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    id_rs         = 6'd1;
    id_rt         = 6'd2;
    ex_rd         = 6'd5;
    ex_reg_wrt    = 1'b1;
    ex_mem_to_reg = (hz != 0);
    case (hz)
      1: begin id_uses_rs = 1'b1; id_rs = 6'd5; end
      2: begin id_uses_rs = 1'b1; id_rs = 6'd0; ex_rd = 6'd0; end
      3: begin id_uses_rt = 1'b1; id_rt = 6'd5; id_uses_rs = 1'b1; end
      default: begin id_uses_rs = 1'b1; id_rs = 6'd5; ex_mem_to_reg = 1'b0; end
    endcase
    {wb_jump_mem, wb_jump, wb_branch_n, wb_branch_z, wb_n, wb_z} = wb;
  endtask

  task automatic expo(input int d, input logic [6:0] e, input string nm);
    exp_t x;
    x.dut = d; x.perf = 1'b0; x.exp = e; x.es = 0; x.er = 0; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic expp(input int d, input int s, input int r, input string nm);
    exp_t x;
    x.dut = d; x.perf = 1'b1; x.exp = '0; x.es = s; x.er = r; x.nm = nm;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        n_vec++;
        if (x.perf) begin
          if (stall_w[x.dut] != 32'(x.es) || redir_w[x.dut] != 32'(x.er)) begin
            n_bad++;
            $display("FAIL %s dut%0d: stall_cycles=%0d redirect_count=%0d, expected %0d/%0d",
                     x.nm, x.dut, stall_w[x.dut], redir_w[x.dut], x.es, x.er);
          end
        end else begin
          act = {sel_w[x.dut], pcw_w[x.dut], ifw_w[x.dut], iff_w[x.dut], idf_w[x.dut], exf_w[x.dut]};
          if (act !== x.exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: {sel,pcw,ifw,iff,idf,exf} got %b expected %b",
                     x.nm, x.dut, act, x.exp);
          end
        end
      end
    end
  end

  initial begin : stim
    step(1, 0, WB_NONE);      expo(0, O_RST, "rst_c0");
    step(1, 0, WB_NONE);      expo(0, O_RST, "rst_c1");     expo(1, O_RST, "rst_b");
    step(0, 0, WB_NONE);      expo(0, O_NORM, "run_idle");  expo(2, O_NORM, "run_idle_c");
    step(0, 1, WB_NONE);      expo(0, O_STL, "ld_use_rs");  expo(1, O_STL, "b_stall1");
    step(0, 0, WB_NONE);      expo(0, O_NORM, "ld_use_1cyc"); expo(1, O_STL, "b_stall2");
    step(0, 0, WB_NONE);      expo(1, O_STL, "b_stall3");
    step(0, 0, WB_NONE);      expo(1, O_NORM, "b_stall_end");
    step(0, 2, WB_NONE);      expo(0, O_NORM, "zero_reg_hw"); expo(2, O_STL, "zero_reg_soft");
    step(0, 3, WB_NONE);      expo(0, O_STL, "ld_use_rt");
    step(0, 0, WB_NONE);      expo(0, O_NORM, "ld_use_rt_end");
    step(0, 0, WB_NONE);
    step(0, 0, WB_BZ_TAKEN);  expo(0, O_RD1, "br_z_taken");
    step(0, 0, WB_J);         expo(0, O_NORM, "drain1_ignore");
    step(0, 0, WB_J);         expo(0, O_NORM, "drain2_ignore");
    step(0, 0, WB_BN_NOT);    expo(0, O_NORM, "bn_not_taken");
    step(0, 0, WB_BN_TAKEN);  expo(0, O_RD1, "bn_taken");
    step(0, 1, WB_NONE);      expo(0, O_STL, "hazard_in_drain");
    step(0, 0, WB_J);         expo(0, O_NORM, "drain_after_hz"); expo(1, O_RD1, "redir_in_stall");
    step(0, 0, WB_NONE);      expo(1, O_NORM, "b_drain1");
    step(0, 0, WB_NONE);
    step(0, 1, WB_JMJ);       expo(0, O_RD2, "jm_over_hz");  expo(1, O_RD2, "jm_over_hz_b");
    step(0, 0, WB_NONE);      expo(0, O_NORM, "no_stall_after"); expo(1, O_NORM, "no_stall_after_b");
    step(0, 0, WB_NONE);
    // perf: 3 single-cycle stalls on dut 0, then 2 redirects
    step(1, 0, WB_NONE);      expo(0, O_RST, "rst_perf");
    step(0, 1, WB_NONE);      expo(0, O_STL, "perf_stall1");
    step(0, 0, WB_NONE);
    step(0, 1, WB_NONE);      expo(0, O_STL, "perf_stall2");
    step(0, 0, WB_NONE);
    step(0, 1, WB_NONE);      expo(0, O_STL, "perf_stall3");
    step(0, 0, WB_NONE);
    step(0, 0, WB_J);         expo(0, O_RD1, "perf_redir1");
    step(0, 0, WB_NONE);
    step(0, 0, WB_NONE);
    step(0, 0, WB_J);         expo(0, O_RD1, "perf_redir2");
    step(0, 0, WB_NONE);      expp(0, EXP_STALLS, EXP_REDIRS, "perf_counts");
    step(0, 0, WB_NONE);
    // reset while dut 1 is mid-STALL
    step(0, 1, WB_NONE);      expo(1, O_STL, "b_enter_stall");
    step(1, 0, WB_NONE);      expo(1, O_RST, "rst_mid_stall");
    step(0, 0, WB_NONE);      expo(1, O_NORM, "stall_aborted");
    expp(1, 0, 0, "perf_clr_b");  expp(0, 0, 0, "perf_clr_a");
    // reset while dut 0 is mid-DRAIN; taken is masked during reset
    step(0, 0, WB_J);         expo(0, O_RD1, "redir_pre_rst");
    step(1, 0, WB_J);         expo(0, O_RST, "rst_mid_drain");
    step(0, 0, WB_J);         expo(0, O_RD1, "drain_aborted");
    step(0, 0, WB_NONE);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
